// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline stage with a valid/ready handshake, an
// optional two-entry skid buffer, a synchronous flush, and RV32 load-data
// extraction / sign-zero extension performed at capture time.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             synchronous discard of all held entries
//   in_valid/in_ready upstream handshake from the MEM stage
//   read_data         raw data-memory word
//   alu_result        ALU result / effective address (low 2 bits = byte offset)
//   rd, memtoreg,     destination register, load-vs-ALU select,
//   regwrite, funct3  register write enable, load type
//   out_valid/out_ready downstream handshake to writeback
//   wb_data, rd_out   registered writeback value and destination
//   regwrite_out      out_valid & regwrite & (rd != x0)
module mem_wb_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5,
    parameter int unsigned SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] alu_result,
    input  logic [RA_W-1:0] rd,
    input  logic            memtoreg,
    input  logic            regwrite,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RA_W-1:0] rd_out,
    output logic            regwrite_out
);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RA_W-1:0] rd;
        logic            regwrite;
    } entry_t;

    // Load formatting; byte/half selected from the low address bits.
    logic [1:0]      off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] fmt_data;
    entry_t          in_entry;

    always_comb begin
        off      = alu_result[1:0];
        byte_sel = read_data[7:0];
        half_sel = off[1] ? read_data[31:16] : read_data[15:0];
        fmt_data = read_data;
        unique case (off)
            2'd0: byte_sel = read_data[7:0];
            2'd1: byte_sel = read_data[15:8];
            2'd2: byte_sel = read_data[23:16];
            2'd3: byte_sel = read_data[31:24];
            default: byte_sel = read_data[7:0];
        endcase
        if (XLEN == 32) begin
            case (funct3)
                3'b000:  fmt_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                3'b100:  fmt_data = XLEN'(byte_sel);
                3'b001:  fmt_data = {{(XLEN-16){half_sel[15]}}, half_sel};
                3'b101:  fmt_data = XLEN'(half_sel);
                default: fmt_data = read_data;
            endcase
        end
        in_entry.data     = memtoreg ? fmt_data : alu_result;
        in_entry.rd       = rd;
        in_entry.regwrite = regwrite;
    end

    // Main entry drives the outputs in both configurations.
    entry_t main_q, main_d;
    logic   main_v_q, main_v_d;
    logic   in_fire, out_fire;

    assign out_valid    = main_v_q;
    assign wb_data      = main_q.data;
    assign rd_out       = main_q.rd;
    assign regwrite_out = main_v_q & main_q.regwrite & (main_q.rd != RA_W'(0));
    assign out_fire     = main_v_q & out_ready;
    assign in_fire      = in_valid & in_ready;

    if (SKID != 0) begin : g_skid
        entry_t skid_q, skid_d;
        logic   skid_v_q, skid_v_d;
        logic   in_ready_q, in_ready_d;

        assign in_ready = in_ready_q;

        // Next-state: main refills from skid first to keep FIFO order.
        always_comb begin
            main_d     = main_q;
            main_v_d   = main_v_q;
            skid_d     = skid_q;
            skid_v_d   = skid_v_q;
            if (!main_v_q || out_fire) begin
                if (skid_v_q) begin
                    main_d   = skid_q;
                    main_v_d = 1'b1;
                    skid_v_d = in_fire;
                    if (in_fire) begin
                        skid_d = in_entry;
                    end
                end else begin
                    main_v_d = in_fire;
                    if (in_fire) begin
                        main_d = in_entry;
                    end
                end
            end else if (in_fire) begin
                skid_d   = in_entry;
                skid_v_d = 1'b1;
            end
            in_ready_d = ~skid_v_d;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                main_q     <= '0;
                main_v_q   <= 1'b0;
                skid_q     <= '0;
                skid_v_q   <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (flush) begin
                main_v_q   <= 1'b0;
                skid_v_q   <= 1'b0;
                in_ready_q <= 1'b1;
            end else begin
                main_q     <= main_d;
                main_v_q   <= main_v_d;
                skid_q     <= skid_d;
                skid_v_q   <= skid_v_d;
                in_ready_q <= in_ready_d;
            end
        end
    end else begin : g_noskid
        assign in_ready = ~main_v_q | out_ready;

        always_comb begin
            main_d   = main_q;
            main_v_d = main_v_q;
            if (in_fire) begin
                main_d   = in_entry;
                main_v_d = 1'b1;
            end else if (out_fire) begin
                main_v_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                main_q   <= '0;
                main_v_q <= 1'b0;
            end else if (flush) begin
                main_v_q <= 1'b0;
            end else begin
                main_q   <= main_d;
                main_v_q <= main_v_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: drives a SKID=1 and a SKID=0 instance with the same
// stimulus; each is compared against a queue-based FIFO reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, memtoreg, regwrite, out_ready;
    logic [31:0] read_data, alu_result;
    logic [4:0]  rd;
    logic [2:0]  funct3;

    logic        in_ready1, out_valid1, regwrite_out1;
    logic [31:0] wb_data1;
    logic [4:0]  rd_out1;
    logic        in_ready0, out_valid0, regwrite_out0;
    logic [31:0] wb_data0;
    logic [4:0]  rd_out0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .RA_W(5), .SKID(1)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .read_data(read_data), .alu_result(alu_result), .rd(rd),
        .memtoreg(memtoreg), .regwrite(regwrite), .funct3(funct3),
        .out_valid(out_valid1), .out_ready(out_ready),
        .wb_data(wb_data1), .rd_out(rd_out1), .regwrite_out(regwrite_out1)
    );

    mem_wb_stage #(.XLEN(32), .RA_W(5), .SKID(0)) u_dut_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .read_data(read_data), .alu_result(alu_result), .rd(rd),
        .memtoreg(memtoreg), .regwrite(regwrite), .funct3(funct3),
        .out_valid(out_valid0), .out_ready(out_ready),
        .wb_data(wb_data0), .rd_out(rd_out0), .regwrite_out(regwrite_out0)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
    } ent_t;

    ent_t        q1[$];
    ent_t        q0[$];
    logic [31:0] delivered[$];
    bit          record = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference load formatting from plain shifts and masks.
    function automatic logic [31:0] ref_format(input logic [31:0] rdata, input logic [31:0] alu,
                                               input logic [2:0] f3, input logic m2r);
        int unsigned o, b, h;
        if (!m2r) return alu;
        o = alu % 4;
        b = (rdata >> (8 * o)) & 32'hFF;
        h = (rdata >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    task automatic check_outputs();
        // SKID=1 instance: capacity 2, in_ready reflects free skid slot.
        check_eq("s1_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
        check_eq("s1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
        if (q1.size() > 0) begin
            check_eq("s1_wb_data", wb_data1, q1[0].data);
            check_eq("s1_rd_out", 32'(rd_out1), 32'(q1[0].rd));
            check_eq("s1_regwrite_out", 32'(regwrite_out1), 32'(q1[0].rw && q1[0].rd != 0));
        end else begin
            check_eq("s1_regwrite_out_idle", 32'(regwrite_out1), 32'd0);
        end
        // SKID=0 instance: capacity 1, in_ready combinational on out_ready.
        check_eq("s0_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
        check_eq("s0_in_ready", 32'(in_ready0), 32'(q0.size() == 0 || out_ready));
        if (q0.size() > 0) begin
            check_eq("s0_wb_data", wb_data0, q0[0].data);
            check_eq("s0_rd_out", 32'(rd_out0), 32'(q0[0].rd));
            check_eq("s0_regwrite_out", 32'(regwrite_out0), 32'(q0[0].rw && q0[0].rd != 0));
        end else begin
            check_eq("s0_regwrite_out_idle", 32'(regwrite_out0), 32'd0);
        end
    endtask

    // One cycle: drive at negedge, check, advance the models at posedge.
    task automatic step(input logic iv, input logic [31:0] rdata, input logic [31:0] alu,
                        input logic [4:0] rdv, input logic m2r, input logic rw,
                        input logic [2:0] f3, input logic ordy, input logic fl,
                        input logic rst, output bit fired1);
        ent_t e;
        bit   f0;
        in_valid   = iv;
        read_data  = rdata;
        alu_result = alu;
        rd         = rdv;
        memtoreg   = m2r;
        regwrite   = rw;
        funct3     = f3;
        out_ready  = ordy;
        flush      = fl;
        reset      = rst;
        #1;
        check_outputs();
        if (record && out_valid1 && ordy) delivered.push_back(wb_data1);
        fired1 = iv && (q1.size() < 2);
        f0     = iv && (q0.size() == 0 || ordy);
        e.data = ref_format(rdata, alu, f3, m2r);
        e.rd   = rdv;
        e.rw   = rw;
        @(posedge clk);
        if (rst || fl) begin
            q1.delete();
            q0.delete();
            fired1 = 1'b0;
        end else begin
            if (q1.size() > 0 && ordy) void'(q1.pop_front());
            if (fired1) q1.push_back(e);
            if (q0.size() > 0 && ordy) void'(q0.pop_front());
            if (f0) q0.push_back(e);
        end
        @(negedge clk);
    endtask

    logic [31:0] stream[4];
    int          idx;
    bit          f1;

    initial begin
        stream[0] = 32'h0000_00A0;
        stream[1] = 32'h0000_00B0;
        stream[2] = 32'h0000_00C0;
        stream[3] = 32'h0000_00D0;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        read_data = '0; alu_result = '0; rd = '0; memtoreg = 1'b0; regwrite = 1'b0; funct3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state.
        check_eq("rst_out_valid", 32'(out_valid1), 32'd0);
        check_eq("rst_regwrite_out", 32'(regwrite_out1), 32'd0);
        check_eq("rst_wb_data", wb_data1, 32'd0);
        check_eq("rst_rd_out", 32'(rd_out1), 32'd0);
        check_eq("rst_in_ready_s1", 32'(in_ready1), 32'd1);
        check_eq("rst_in_ready_s0", 32'(in_ready0), 32'd1);

        // Single LB after reset.
        step(1, 32'h80FF7F01, 32'h1003, 5'd5, 1, 1, 3'b000, 1, 0, 0, f1);
        check_eq("lb_out_valid", 32'(out_valid1), 32'd1);
        check_eq("lb_wb_data", wb_data1, 32'hFFFF_FF80);
        check_eq("lb_rd_out", 32'(rd_out1), 32'd5);
        check_eq("lb_regwrite_out", 32'(regwrite_out1), 32'd1);

        // Format sweep.
        step(1, 32'h80FF7F01, 32'h1001, 5'd6, 1, 1, 3'b100, 1, 0, 0, f1);
        check_eq("lbu_off1", wb_data1, 32'h0000_007F);
        step(1, 32'h80FF7F01, 32'h1002, 5'd7, 1, 1, 3'b001, 1, 0, 0, f1);
        check_eq("lh_off2", wb_data1, 32'hFFFF_80FF);
        step(1, 32'h80FF7F01, 32'h1000, 5'd8, 1, 1, 3'b101, 1, 0, 0, f1);
        check_eq("lhu_off0", wb_data1, 32'h0000_7F01);
        step(1, 32'h80FF7F01, 32'h1003, 5'd9, 1, 1, 3'b010, 1, 0, 0, f1);
        check_eq("lw", wb_data1, 32'h80FF_7F01);
        step(1, 32'h80FF7F01, 32'h1234, 5'd10, 0, 1, 3'b000, 1, 0, 0, f1);
        check_eq("alu_pass", wb_data1, 32'h0000_1234);
        check_eq("alu_pass_s0", wb_data0, 32'h0000_1234);

        // Write to x0 is never asserted.
        step(1, 32'h0, 32'h55, 5'd0, 0, 1, 3'b010, 1, 0, 0, f1);
        check_eq("x0_out_valid", 32'(out_valid1), 32'd1);
        check_eq("x0_regwrite_out", 32'(regwrite_out1), 32'd0);
        step(0, 32'h0, 32'h0, 5'd0, 0, 0, 3'b000, 1, 0, 0, f1);

        // Back-pressure: stream A..D with out_ready low, then release.
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            step(idx < 4, 32'h0, (idx < 4) ? stream[idx] : 32'h0, 5'(idx + 1), 0, 1, 3'b010, 0, 0, 0, f1);
            if (f1) idx++;
        end
        check_eq("bp_accepted", 32'(idx), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready1), 32'd0);
        check_eq("bp_hold_a", wb_data1, 32'h0000_00A0);
        check_eq("bp_hold_valid", 32'(out_valid1), 32'd1);
        record = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(idx < 4, 32'h0, (idx < 4) ? stream[idx] : 32'h0, 5'(idx + 1), 0, 1, 3'b010, 1, 0, 0, f1);
            if (f1) idx++;
        end
        record = 1'b0;
        check_eq("bp_count", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_order", (i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF, stream[i]);
        end

        // Flush while both entries are full and an input is presented.
        step(1, 32'h0, 32'h111, 5'd1, 0, 1, 3'b010, 0, 0, 0, f1);
        step(1, 32'h0, 32'h222, 5'd2, 0, 1, 3'b010, 0, 0, 0, f1);
        step(1, 32'h0, 32'h333, 5'd3, 0, 1, 3'b010, 0, 1, 0, f1);
        check_eq("fl_out_valid", 32'(out_valid1), 32'd0);
        check_eq("fl_regwrite_out", 32'(regwrite_out1), 32'd0);
        check_eq("fl_in_ready", 32'(in_ready1), 32'd1);
        check_eq("fl_out_valid_s0", 32'(out_valid0), 32'd0);
        repeat (3) step(0, 32'h0, 32'h0, 5'd0, 0, 0, 3'b000, 1, 0, 0, f1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1, f1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline stage, the successor of the plain MEM/WB register. It adds:
- a valid/ready handshake with an optional two-entry skid buffer, so writeback back-pressure does not create a combinational ready path into MEM;
- a synchronous flush;
- RV32 load-data extraction and sign/zero extension at capture time, so the register file sees a final registered writeback value.

The block sits between the data-memory read port and the register-file write port.

## Interface
Parameters:
- XLEN, 32: datapath width (32 only for load formatting; other widths pass words through).
- RA_W, 5: register-address width.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  MEM stage holds a valid entry.
- in_ready  out  1  stage can accept this cycle.
- read_data  in  XLEN  raw data-memory word.
- alu_result  in  XLEN  ALU result / effective address.
- rd  in  RA_W  destination register.
- memtoreg  in  1  1 = write back load data, 0 = write back alu_result.
- regwrite  in  1  instruction writes rd.
- funct3  in  3  load type.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes the entry.
- wb_data  out  XLEN  final writeback value.
- rd_out  out  RA_W  registered rd.
- regwrite_out  out  1  out_valid & regwrite_q & (rd_q != 0).

## Operation
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- Format at capture, with off = alu_result[1:0]:
  - funct3 000 LB: sign-extended byte at off.
  - 100 LBU: zero-extended byte at off.
  - 001 LH: sign-extended half selected by off[1]; off[0] ignored.
  - 101 LHU: zero-extended half selected by off[1].
  - 010 LW and 011/110/111: whole word; off ignored.
- wb_data_next = memtoreg ? formatted : alu_result. Stored per entry together with rd and regwrite.
- SKID=1 uses two entries, main (drives outputs) and skid.
  - in_ready = ~skid_valid, registered.
  - Main empty or output fire: main loads from skid if skid_valid, else from the input on input fire. If main refilled from skid while an input fires, the input goes to skid.
  - Main full, no output fire, input fire: input goes to skid.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- SKID=0 uses one entry.
  - in_ready = ~out_valid | out_ready.
  - Main loads on input fire; otherwise it clears on output fire.
- Flush: both valids clear at the next edge. An input firing in the same cycle is discarded. Payload registers may hold stale data, but out_valid = 0 and regwrite_out = 0.
- Priority: reset > flush > normal.
- Writes to x0 are never asserted on regwrite_out.

## Timing
- Reset values: out_valid 0, regwrite_out 0, wb_data 0, rd_out 0, skid entry invalid and zero.
  - SKID=1: in_ready 1 in the cycle after reset.
  - SKID=0: in_ready = 1 because out_valid = 0.
- Latency: input fire in cycle N gives out_valid with the formatted wb_data in cycle N+1. No combinational path from read_data to wb_data.
- SKID=1: no combinational path from out_ready to in_ready. in_ready drops the cycle after the skid fills and rises the cycle after the skid drains.
- Full throughput, 1 entry/cycle, while out_ready = 1.
- Outputs are stable while out_valid & ~out_ready: wb_data, rd_out and regwrite_out hold.
- Reset or flush mid-stall: entries are lost. The next accepted input appears 1 cycle after its fire.
- Boundaries:
  - Both entries full with a simultaneous input and output fire is impossible, because in_ready = 0.
  - Both entries full with an output fire: skid moves to main and the skid frees.

## Test plan
- Reset then single LB: read_data=0x80FF7F01, alu_result=0x1003, funct3=000, memtoreg=1, rd=5 → next cycle out_valid=1, wb_data=0xFFFFFF80, rd_out=5, regwrite_out=1.
- Format sweep on read_data=0x80FF7F01:
  - LBU off=1 → 0x0000007F.
  - LH off=2 → 0xFFFF80FF.
  - LHU off=0 → 0x00007F01.
  - LW → 0x80FF7F01.
  - memtoreg=0, alu_result=0x1234 → 0x00001234.
- Back-pressure (SKID=1): stream entries A,B,C,D, hold out_ready=0 for 3 cycles → A held on outputs, B in skid, in_ready=0 from the cycle after B is accepted. Then release → A,B,C,D delivered in order, none lost or duplicated.
- Flush while both entries full and in_valid=1 → next cycle out_valid=0 and regwrite_out=0 (SKID=1: in_ready=1). The flushed-cycle input never appears.
- rd=0 with regwrite=1 → out_valid=1, regwrite_out=0.
- SKID=0 run of the back-pressure scenario → in_ready follows ~out_valid | out_ready combinationally, same ordering; full rate with out_ready=1.
